// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit 5-stage CPU.
package cpu_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned INST_W = 16;

  localparam logic [15:0] NOP_INST = 16'h0000;

  // Opcode field (inst[15:12])
  localparam logic [3:0] OP_ADD     = 4'h0;
  localparam logic [3:0] OP_SUB     = 4'h1;
  localparam logic [3:0] OP_AND     = 4'h2;
  localparam logic [3:0] OP_OR      = 4'h3;
  localparam logic [3:0] OP_XOR     = 4'h4;
  localparam logic [3:0] OP_NOT     = 4'h5;
  localparam logic [3:0] OP_SHL     = 4'h6;
  localparam logic [3:0] OP_SHR     = 4'h7;
  localparam logic [3:0] OP_LOAD    = 4'h8;
  localparam logic [3:0] OP_STORE   = 4'h9;
  localparam logic [3:0] OP_BR      = 4'hA;
  localparam logic [3:0] OP_BRZ     = 4'hB;
  localparam logic [3:0] OP_BRN     = 4'hC;
  localparam logic [3:0] OP_BRSUB   = 4'hD;
  localparam logic [3:0] OP_RETURN  = 4'hE;
  localparam logic [3:0] OP_LOADIMM = 4'hF;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {inst, pc} holding register for a word fetched while decode is stalled.
module fetch_skid_buffer #(
  parameter int unsigned INST_W = 16,
  parameter int unsigned PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [INST_W-1:0] wr_inst,
  input  logic [PC_W-1:0]   wr_pc,
  output logic [INST_W-1:0] rd_inst,
  output logic [PC_W-1:0]   rd_pc,
  output logic              full
);

  // Clear has priority over load, load over unload.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full    <= 1'b0;
      rd_inst <= '0;
      rd_pc   <= '0;
    end else if (load) begin
      full    <= 1'b1;
      rd_inst <= wr_inst;
      rd_pc   <= wr_pc;
    end else if (unload) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack sequencer and IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic [PC_W-1:0]   if_pc_plus1,
  output logic              if_valid
);

  import cpu_pkg::*;

  fetch_state_t      state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_inc;
  logic              fetch_done;
  logic              skid_load;
  logic              skid_unload;
  logic              skid_clear;
  logic [INST_W-1:0] skid_inst;
  logic [PC_W-1:0]   skid_pc;
  logic [PC_W-1:0]   skid_pc_inc;
  logic              skid_full;

  // Skid buffer control and PC increments (modulo 2^PC_W).
  always_comb begin
    pc_inc      = pc + PC_W'(1);
    skid_pc_inc = skid_pc + PC_W'(1);
    fetch_done  = imem_req && imem_ack;
    skid_load   = !redirect && (state == FETCH) && stall && fetch_done;
    skid_unload = !redirect && (state == HOLD) && !stall;
    skid_clear  = redirect;
  end

  fetch_skid_buffer #(
    .INST_W (INST_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (skid_clear),
    .wr_inst (imem_rdata),
    .wr_pc   (pc),
    .rd_inst (skid_inst),
    .rd_pc   (skid_pc),
    .full    (skid_full)
  );

  // Fetch sequencer, PC, registered imem request and IF/ID register.
  // imem_addr is its own register so it can stay on the old address in DISCARD
  // while pc already holds the redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      if_inst     <= INST_W'(NOP_INST);
      if_pc       <= '0;
      if_pc_plus1 <= PC_W'(1);
      if_valid    <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      if_inst  <= INST_W'(NOP_INST);
      if_valid <= 1'b0;
      if (imem_req && !imem_ack) begin
        state <= DISCARD;
      end else begin
        state     <= FETCH;
        imem_req  <= 1'b1;
        imem_addr <= redirect_pc;
      end
    end else begin
      case (state)
        FETCH: begin
          if (fetch_done) begin
            pc <= pc_inc;
            if (stall) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end else begin
              if_inst     <= imem_rdata;
              if_pc       <= pc;
              if_pc_plus1 <= pc_inc;
              if_valid    <= 1'b1;
              imem_req    <= 1'b1;
              imem_addr   <= pc_inc;
            end
          end else begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            if (!stall) begin
              if_inst  <= INST_W'(NOP_INST);
              if_valid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_inst     <= skid_inst;
            if_pc       <= skid_pc;
            if_pc_plus1 <= skid_pc_inc;
            if_valid    <= skid_full;
            state       <= FETCH;
            imem_req    <= 1'b1;
            imem_addr   <= pc;
          end
        end
        DISCARD: begin
          if (!stall) begin
            if_inst  <= INST_W'(NOP_INST);
            if_valid <= 1'b0;
          end
          if (imem_ack) begin
            state     <= FETCH;
            imem_addr <= pc;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
